// File: rtl/nios_system_timer_seq_master.sv
// ----------------------------------------------------------------------------
// nios_system_timer_seq_master
//   Avalon-MM master that runs a complete interval-timer sequence in hardware:
//   program period, start, count irq timeouts (acking each), stop, latch the
//   counter snapshot and read it back. Gives hardware blocks self-timed delays.
//
// Optional feature macro: TIMER_SEQ_WATCHDOG_EN
//   Defined   -> parameter WAIT_LIMIT bounds every irq wait; on expiry the
//                sequence jumps to STOP and err pulses together with done.
//   Undefined -> WAIT waits indefinitely, err is tied to 0.
//
// Ports
//   clk, reset_n           clock, synchronous active-low reset
//   cmd_valid/cmd_ready    command handshake (ready only in IDLE)
//   cmd_period, cmd_count  timer reload value, number of timeouts (0 -> 1)
//   busy, done, err        status: busy accept..done, done/err one-cycle pulses
//   snapshot               32-bit counter snapshot, held until next done
//   timeouts_seen          irqs acknowledged in current/last command
//   m_*                    Avalon-MM master to the timer slave (no waitrequest,
//                          readdata valid the cycle after the read address)
//   m_irq                  timer irq, level, cleared by a status write
//
// All outputs except err (when the macro is off) are registered. The bus
// registers are loaded from the state being entered, so an access is on the
// bus exactly during the cycle its state is occupied.
// ----------------------------------------------------------------------------
module nios_system_timer_seq_master
`ifdef TIMER_SEQ_WATCHDOG_EN
  #(parameter logic [31:0] WAIT_LIMIT = 32'd1_000_000)
`endif
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_period,
  input  logic [15:0] cmd_count,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] snapshot,
  output logic [15:0] timeouts_seen,
  output logic [2:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [15:0] m_writedata,
  input  logic [15:0] m_readdata,
  input  logic        m_irq
);

  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned PERIOD_W = 32;
  localparam int unsigned CNT_W    = 16;

  localparam logic [ADDR_W-1:0] ADDR_STATUS   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_CONTROL  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_PERIOD_L = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ADDR_PERIOD_H = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] ADDR_SNAP_L   = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ADDR_SNAP_H   = ADDR_W'(5);

  // Control register: {STOP, START, CONT, ITO}
  localparam logic [DATA_W-1:0] CTRL_RUN_ONCE = DATA_W'(16'h0005);
  localparam logic [DATA_W-1:0] CTRL_RUN_CONT = DATA_W'(16'h0007);
  localparam logic [DATA_W-1:0] CTRL_STOP     = DATA_W'(16'h0008);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_PL, S_WR_PH, S_WR_CLR, S_WR_CTRL, S_WAIT, S_ACK, S_GAP,
    S_STOP, S_SNAP, S_RD_L, S_RD_H, S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [PERIOD_W-1:0]   period_q, period_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [CNT_W-1:0]      seen_q, seen_d;
  logic [DATA_W-1:0]     snap_lo_q, snap_lo_d;
  logic [PERIOD_W-1:0]   snapshot_q, snapshot_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  cs_q, cs_d;
  logic                  wr_n_q, wr_n_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
`ifdef TIMER_SEQ_WATCHDOG_EN
  logic [31:0]           wait_cnt_q, wait_cnt_d;
  logic                  abort_q, abort_d;
  logic                  err_q, err_d;
`endif

  // State and output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      period_q    <= '0;
      count_q     <= '0;
      seen_q      <= '0;
      snap_lo_q   <= '0;
      snapshot_q  <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cs_q        <= 1'b0;
      wr_n_q      <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
`ifdef TIMER_SEQ_WATCHDOG_EN
      wait_cnt_q  <= '0;
      abort_q     <= 1'b0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      period_q    <= period_d;
      count_q     <= count_d;
      seen_q      <= seen_d;
      snap_lo_q   <= snap_lo_d;
      snapshot_q  <= snapshot_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cs_q        <= cs_d;
      wr_n_q      <= wr_n_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
`ifdef TIMER_SEQ_WATCHDOG_EN
      wait_cnt_q  <= wait_cnt_d;
      abort_q     <= abort_d;
      err_q       <= err_d;
`endif
    end
  end

  // Next-state, datapath and bus outputs for the state being entered
  always_comb begin
    state_d    = state_q;
    period_d   = period_q;
    count_d    = count_q;
    seen_d     = seen_q;
    snap_lo_d  = snap_lo_q;
    snapshot_d = snapshot_q;
    done_d     = 1'b0;
    cs_d       = 1'b0;
    wr_n_d     = 1'b1;
    addr_d     = '0;
    wdata_d    = '0;
`ifdef TIMER_SEQ_WATCHDOG_EN
    wait_cnt_d = '0;
    abort_d    = abort_q;
    err_d      = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          period_d = cmd_period;
          count_d  = (cmd_count == '0) ? CNT_W'(1) : cmd_count;
          seen_d   = '0;
`ifdef TIMER_SEQ_WATCHDOG_EN
          abort_d  = 1'b0;
`endif
          state_d  = S_WR_PL;
        end
      end
      S_WR_PL:   state_d = S_WR_PH;
      S_WR_PH:   state_d = S_WR_CLR;
      S_WR_CLR:  state_d = S_WR_CTRL;
      S_WR_CTRL: state_d = S_WAIT;
      S_WAIT: begin
        // Level-sensitive: an irq already pending on entry counts as a timeout
        if (m_irq) begin
          state_d = S_ACK;
        end
`ifdef TIMER_SEQ_WATCHDOG_EN
        else if ((33'(wait_cnt_q) + 33'd1) >= 33'(WAIT_LIMIT)) begin
          abort_d = 1'b1;
          state_d = S_STOP;
        end else begin
          wait_cnt_d = wait_cnt_q + 32'd1;
        end
`endif
      end
      S_ACK: begin
        seen_d = (seen_q == '1) ? seen_q : seen_q + CNT_W'(1);
        if ((17'(seen_q) + 17'd1) == 17'(count_q)) state_d = S_STOP;
        else                                       state_d = S_GAP;
      end
      // The slave drops irq one cycle after the ack write; skip that cycle
      S_GAP:  state_d = S_WAIT;
      S_STOP: state_d = S_SNAP;
      S_SNAP: state_d = S_RD_L;
      S_RD_L: state_d = S_RD_H;
      S_RD_H: begin
        snap_lo_d = m_readdata;
        state_d   = S_DONE;
      end
      S_DONE: begin
        snapshot_d = {m_readdata, snap_lo_q};
        done_d     = 1'b1;
`ifdef TIMER_SEQ_WATCHDOG_EN
        err_d      = abort_q;
`endif
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_WR_PL: begin
        cs_d = 1'b1; wr_n_d = 1'b0; addr_d = ADDR_PERIOD_L; wdata_d = period_d[15:0];
      end
      S_WR_PH: begin
        cs_d = 1'b1; wr_n_d = 1'b0; addr_d = ADDR_PERIOD_H; wdata_d = period_d[31:16];
      end
      S_WR_CLR, S_ACK: begin
        cs_d = 1'b1; wr_n_d = 1'b0; addr_d = ADDR_STATUS;
      end
      S_WR_CTRL: begin
        cs_d = 1'b1; wr_n_d = 1'b0; addr_d = ADDR_CONTROL;
        wdata_d = (count_d > CNT_W'(1)) ? CTRL_RUN_CONT : CTRL_RUN_ONCE;
      end
      S_STOP: begin
        cs_d = 1'b1; wr_n_d = 1'b0; addr_d = ADDR_CONTROL; wdata_d = CTRL_STOP;
      end
      S_SNAP: begin
        cs_d = 1'b1; wr_n_d = 1'b0; addr_d = ADDR_SNAP_L;
      end
      S_RD_L: begin
        cs_d = 1'b1; addr_d = ADDR_SNAP_L;
      end
      S_RD_H: begin
        cs_d = 1'b1; addr_d = ADDR_SNAP_H;
      end
      default: ;
    endcase
  end

  assign cmd_ready_d = (state_d == S_IDLE);
  assign busy_d      = (state_d != S_IDLE);

  assign cmd_ready     = cmd_ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign snapshot      = snapshot_q;
  assign timeouts_seen = seen_q;
  assign m_chipselect  = cs_q;
  assign m_write_n     = wr_n_q;
  assign m_address     = addr_q;
  assign m_writedata   = wdata_q;
`ifdef TIMER_SEQ_WATCHDOG_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_nios_system_timer_seq_master.sv
// ----------------------------------------------------------------------------
// tb_nios_system_timer_seq_master
//   Randomized bench with a behavioural timer-slave model. The expected bus
//   transaction list, snapshot and timeout count for each command are derived
//   directly from the command and the model's read values.
// ----------------------------------------------------------------------------
module tb_nios_system_timer_seq_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_period = '0;
  logic [15:0] cmd_count = '0;
  logic        busy, done, err;
  logic [31:0] snapshot;
  logic [15:0] timeouts_seen;
  logic [2:0]  m_address;
  logic        m_chipselect, m_write_n;
  logic [15:0] m_writedata;
  logic [15:0] m_readdata = '0;
  logic        m_irq = 1'b0;

`ifdef TIMER_SEQ_WATCHDOG_EN
  localparam int unsigned WLIM = 50;
  nios_system_timer_seq_master #(.WAIT_LIMIT(32'(WLIM))) dut (
`else
  nios_system_timer_seq_master dut (
`endif
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_period(cmd_period), .cmd_count(cmd_count), .busy(busy), .done(done),
    .err(err), .snapshot(snapshot), .timeouts_seen(timeouts_seen),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
    .m_writedata(m_writedata), .m_readdata(m_readdata), .m_irq(m_irq));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- timer slave model ----------------
  int unsigned cyc = 0;
  logic        running = 1'b0, acked = 1'b0, irq_block = 1'b0, cleared_now;
  int unsigned cd = 0, clr_cnt = 0, k_min = 0, k_max = 4, spurious = 0;
  logic [15:0] rd_lo = '0, rd_hi = '0;
  logic        rd_pend = 1'b0;
  logic [2:0]  rd_pend_addr = '0;
  logic [31:0] obs_q[$];
  int unsigned obs_cyc[$];

  function automatic logic [31:0] wr_t(input logic [2:0] a, input logic [15:0] d);
    return {12'h0, 1'b0, a, d};
  endfunction
  function automatic logic [31:0] rd_t(input logic [2:0] a);
    return {12'h0, 1'b1, a, 16'h0};
  endfunction

  always @(negedge clk) begin
    cyc++;
    // registered readdata: answer the read seen on the previous cycle
    if (rd_pend) m_readdata = (rd_pend_addr == 3'd4) ? rd_lo : (rd_pend_addr == 3'd5) ? rd_hi : 16'h0;
    rd_pend = 1'b0;
    cleared_now = 1'b0;
    if (clr_cnt != 0) begin
      clr_cnt--;
      if (clr_cnt == 0) begin
        m_irq = 1'b0; acked = 1'b0; cleared_now = 1'b1;
        cd = $urandom_range(k_max, k_min);
      end
    end
    if (!reset_n) begin
      running = 1'b0; m_irq = 1'b0; clr_cnt = 0; acked = 1'b0;
    end else if (m_chipselect) begin
      obs_q.push_back(m_write_n ? rd_t(m_address) : wr_t(m_address, m_writedata));
      obs_cyc.push_back(cyc);
      if (!m_write_n) begin
        if (m_address == 3'd1) begin
          if (m_writedata[3]) begin
            running = 1'b0; m_irq = 1'b0; clr_cnt = 0; acked = 1'b0;
          end else if (m_writedata[2]) begin
            running = 1'b1; cd = $urandom_range(k_max, k_min);
          end
        end else if (m_address == 3'd0 && running) begin
          // irq is dropped two edges after the ack, i.e. one cycle late
          if (m_irq && !acked) begin acked = 1'b1; clr_cnt = 2; end
          else spurious++;
        end
      end else begin
        rd_pend = 1'b1; rd_pend_addr = m_address;
      end
    end
    if (running && !m_irq && !cleared_now && !irq_block) begin
      if (cd == 0) m_irq = 1'b1;
      else cd--;
    end
  end

  // ---------------- command runner ----------------
  logic [31:0] prev_snap = '0;

  task automatic run_cmd(input logic [31:0] period, input logic [15:0] count,
                         input logic [15:0] lo, input logic [15:0] hi,
                         input int unsigned kmin, input int unsigned kmax,
                         input bit hold_valid, input int unsigned block_cycles,
                         input bit expect_abort);
    logic [31:0] exp_q[$];
    int unsigned neff, n, limit;
    neff = (count == 0) ? 1 : int'(count);
    k_min = kmin; k_max = kmax; rd_lo = lo; rd_hi = hi;
    obs_q.delete(); obs_cyc.delete(); spurious = 0;
    irq_block = (block_cycles != 0) || expect_abort;

    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    check_eq("ready_before_cmd", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_period = period; cmd_count = count;
    @(negedge clk);
    check_eq("busy_after_accept", 32'(busy), 32'd1);
    check_eq("ready_low_busy", 32'(cmd_ready), 32'd0);
    check_eq("snap_held", snapshot, prev_snap);
    if (!hold_valid) begin
      cmd_valid = 1'b0; cmd_period = $urandom; cmd_count = 16'($urandom);
    end

    if (block_cycles != 0 && !expect_abort) begin
      repeat (block_cycles) @(negedge clk);
      check_eq("blocked_busy", 32'(busy), 32'd1);
      check_eq("blocked_no_access", 32'(obs_q.size()), 32'd4);
      irq_block = 1'b0;
    end

    limit = 100 + neff * (kmax + 8);
`ifdef TIMER_SEQ_WATCHDOG_EN
    if (expect_abort) limit = limit + WLIM;
`endif
    n = 0;
    while (!done && n < limit) begin @(negedge clk); n++; end
    check_eq("done_seen", 32'(done), 32'd1);
    cmd_valid = 1'b0;

    exp_q.push_back(wr_t(3'd2, period[15:0]));
    exp_q.push_back(wr_t(3'd3, period[31:16]));
    exp_q.push_back(wr_t(3'd0, 16'h0));
    exp_q.push_back(wr_t(3'd1, (neff > 1) ? 16'h7 : 16'h5));
    if (!expect_abort) for (int i = 0; i < int'(neff); i++) exp_q.push_back(wr_t(3'd0, 16'h0));
    exp_q.push_back(wr_t(3'd1, 16'h8));
    exp_q.push_back(wr_t(3'd4, 16'h0));
    exp_q.push_back(rd_t(3'd4));
    exp_q.push_back(rd_t(3'd5));

    check_eq("bus_count", 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check_eq($sformatf("bus_txn%0d", i), obs_q[i], exp_q[i]);
    check_eq("spurious_ack", 32'(spurious), 32'd0);
    check_eq("snapshot", snapshot, {hi, lo});
    check_eq("timeouts_seen", 32'(timeouts_seen), expect_abort ? 32'd0 : 32'(neff));
    check_eq("err", 32'(err), expect_abort ? 32'd1 : 32'd0);
    check_eq("busy_at_done", 32'(busy), 32'd0);
    check_eq("ready_at_done", 32'(cmd_ready), 32'd1);
`ifdef TIMER_SEQ_WATCHDOG_EN
    if (expect_abort && obs_cyc.size() > 4)
      check_eq("wdog_stop_cycle", 32'(obs_cyc[4] - obs_cyc[3]), 32'(WLIM + 1));
`endif
    prev_snap = {hi, lo};
    irq_block = 1'b0;
    @(negedge clk);
    check_eq("done_one_cycle", 32'(done), 32'd0);
    check_eq("no_reaccept", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_ctl"}, {26'h0, cmd_ready, busy, done, err, m_chipselect, m_write_n}, 32'b100001);
    check_eq({tag, "_snap"}, snapshot, 32'h0);
    check_eq({tag, "_seen"}, 32'(timeouts_seen), 32'h0);
    check_eq({tag, "_bus"}, {13'h0, m_address, m_writedata}, 32'h0);
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // directed: single timeout, fixed 10-cycle irq delay
    run_cmd(32'h0001_86A0, 16'd1, 16'h1234, 16'h0005, 10, 10, 1'b0, 0, 1'b0);
    // three timeouts, continuous mode
    run_cmd($urandom, 16'd3, 16'($urandom), 16'($urandom), 0, 5, 1'b0, 0, 1'b0);
    // count 0 treated as 1, cmd_valid held for the whole sequence
    run_cmd($urandom, 16'd0, 16'($urandom), 16'($urandom), 0, 5, 1'b1, 0, 1'b0);
    // period 0 passed through
    run_cmd(32'h0, 16'd2, 16'($urandom), 16'($urandom), 0, 3, 1'b0, 0, 1'b0);

    for (int i = 0; i < 12; i++)
      run_cmd($urandom, 16'($urandom_range(4, 0)), 16'($urandom), 16'($urandom),
              0, $urandom_range(6, 0), 1'($urandom_range(1, 0)), 0, 1'b0);

`ifdef TIMER_SEQ_WATCHDOG_EN
    run_cmd($urandom, 16'd1, 16'($urandom), 16'($urandom), 0, 0, 1'b0, 0, 1'b1);
`else
    // irq withheld for a long time: the master keeps waiting
    run_cmd($urandom, 16'd1, 16'($urandom), 16'($urandom), 0, 2, 1'b0, 10000, 1'b0);
`endif

    // reset in the middle of WAIT
    irq_block = 1'b1;
    cmd_valid = 1'b1; cmd_period = $urandom; cmd_count = 16'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("midwait_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_state("midreset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    irq_block = 1'b0;
    @(negedge clk);
    check_eq("post_reset_cs", 32'(m_chipselect), 32'd0);
    prev_snap = '0;
    run_cmd($urandom, 16'd2, 16'($urandom), 16'($urandom), 0, 4, 1'b0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
